// File: rtl/multiplier_pkg.sv
// Shared widths and state encoding for the shift-add multiply-accumulate unit.
package multiplier_pkg;
  localparam int A_WIDTH = 4;
  localparam int B_WIDTH = 2;
  localparam int C_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multiplier4_seq_step.sv
// Conditional-add cell: acc_o = acc_i + (sel_i ? a_i : 0), one per RUN cycle.
module mult_step #(
  parameter int W = 7
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] a_i,
  input  logic         sel_i,
  output logic [W-1:0] acc_o
);
  assign acc_o = acc_i + (sel_i ? a_i : '0);
endmodule

// File: rtl/multiplier4_seq.sv
// Sequential shift-add MAC: Product = Multiplicand * Multiplier + Addend,
// one multiplier bit per RUN cycle, start/busy/done handshake.
module multiplier4_seq #(
  parameter int A_WIDTH = multiplier_pkg::A_WIDTH,
  parameter int B_WIDTH = multiplier_pkg::B_WIDTH,
  parameter int C_WIDTH = multiplier_pkg::C_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [A_WIDTH-1:0]         Multiplicand,
  input  logic [B_WIDTH-1:0]         Multiplier,
  input  logic [C_WIDTH-1:0]         Addend,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH:0]   Product
);
  import multiplier_pkg::*;

  localparam int P_WIDTH = A_WIDTH + B_WIDTH + 1;
  localparam int ITW     = $clog2(B_WIDTH + 1);

  state_t               state_q, state_d;
  logic [P_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d;
  logic [ITW-1:0]       iter_q, iter_d;
  logic [P_WIDTH-1:0]   prod_q, prod_d;
  logic [P_WIDTH-1:0]   step_acc;

  mult_step #(.W(P_WIDTH)) u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .sel_i (b_q[0]),
    .acc_o (step_acc)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = {{(P_WIDTH-A_WIDTH){1'b0}}, Multiplicand};
        b_d     = Multiplier;
        acc_d   = {{(P_WIDTH-C_WIDTH){1'b0}}, Addend};
        iter_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d  = step_acc;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        iter_d = iter_q + 1'b1;
        // Product is only written here, so it holds across later starts.
        if (iter_q == ITW'(B_WIDTH - 1)) begin
          prod_d  = step_acc;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign Product = prod_q;
endmodule

// File: tb/tb_multiplier4_seq.sv
// Bench for multiplier4_seq: timeline reference model checked every cycle,
// directed scenarios with literal expectations, exhaustive sweep, random traffic.
module tb_multiplier4_seq;
  localparam int AW = 4, BW = 2, CW = 3, PW = AW + BW + 1;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] mc = '0;
  logic [BW-1:0] mp = '0;
  logic [CW-1:0] ad = '0;
  logic          busy, done;
  logic [PW-1:0] prod;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  multiplier4_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .Multiplicand(mc), .Multiplier(mp), .Addend(ad),
    .busy(busy), .done(done), .Product(prod)
  );

  // Model: m_cnt counts edges since the accepting edge (-1 = idle).
  int            m_cnt  = -1;
  logic [PW-1:0] m_prod = '0, m_exp = '0;
  logic          m_busy, m_done;
  assign m_busy = (m_cnt >= 0);
  assign m_done = (m_cnt == BW);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = -1;
      m_prod = '0;
    end else if (m_cnt < 0) begin
      if (start) begin
        m_cnt = 0;
        m_exp = PW'(int'(mc) * int'(mp) + int'(ad));
      end
    end else begin
      m_cnt++;
      if (m_cnt == BW) m_prod = m_exp;
      if (m_cnt > BW) m_cnt = -1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    total++;
    if (busy !== m_busy || done !== m_done || prod !== m_prod) begin
      bad++;
      $display("FAIL cycle t=%0t busy/done/Product got %b/%b/%0d want %b/%b/%0d",
               $time, busy, done, prod, m_busy, m_done, m_prod);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // One isolated op; returns start->done latency, busy cycle count, Product at done.
  task automatic op(input int a, input int b, input int c,
                    output int lat, output int busyc, output int pr);
    lat = -1; busyc = 0; pr = -1;
    @(negedge clk);
    mc = AW'(a); mp = BW'(b); ad = CW'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (busy) busyc++;
      if (done && lat < 0) begin lat = n; pr = int'(prod); end
      if (!busy && lat >= 0) break;
      @(negedge clk);
    end
    if (lat < 0) check("op_timeout", lat, BW);
  endtask

  initial begin
    int lat, bc, pr, nd, last, gap;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_prod", int'(prod), 0);
    rst = 1'b0;

    op(4, 2, 1, lat, bc, pr);
    check("basic_prod", pr, 9);
    check("basic_lat", lat, 2);
    check("basic_busy", bc, 3);
    op(15, 3, 7, lat, bc, pr);
    check("max_prod", pr, 52);
    op(0, 0, 0, lat, bc, pr);
    check("zero_prod", pr, 0);
    check("zero_lat", lat, 2);

    // starts during RUN and DONE must be ignored
    @(negedge clk); mc = 4'd5; mp = 2'd1; ad = 3'd2; start = 1'b1;
    @(negedge clk); mc = 4'd9; mp = 2'd3; ad = 3'd6;
    nd = 0;
    for (int n = 0; n < 3; n++) begin
      if (done) nd++;
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_busy_after", int'(busy), 0);
    repeat (3) begin @(negedge clk); if (done) nd++; end
    check("ign_done_count", nd, 1);
    check("ign_prod", int'(prod), 7);

    // start held high
    @(negedge clk); mc = 4'd3; mp = 2'd3; ad = 3'd0; start = 1'b1;
    @(negedge clk);
    nd = 0; last = -1;
    for (int n = 0; n < 16; n++) begin
      if (done) begin
        nd++;
        check("held_prod", int'(prod), 9);
        if (last >= 0) begin gap = n - last; check("held_gap", gap, BW + 2); end
        last = n;
      end
      if (n < 15) @(negedge clk);
    end
    start = 1'b0;
    check("held_done_count", nd, 4);

    // reset in the first RUN cycle
    @(negedge clk); mc = 4'd15; mp = 2'd3; ad = 3'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("pre_rst_busy", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_prod", int'(prod), 0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (6) begin @(negedge clk); if (done) nd++; end
    check("midrst_no_done", nd, 0);
    op(2, 2, 3, lat, bc, pr);
    check("after_rst_prod", pr, 7);

    // exhaustive sweep with divider round trip
    for (int a = 0; a < (1 << AW); a++)
      for (int b = 0; b < (1 << BW); b++)
        for (int c = 0; c < (1 << CW); c++) begin
          op(a, b, c, lat, bc, pr);
          check("sweep_prod", pr, a * b + c);
          if (b > 0 && c < b) check("sweep_divrt", int'(pr / b == a && pr % b == c), 1);
        end

    // random traffic, including starts while busy
    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      mc = AW'($urandom); mp = BW'($urandom); ad = CW'($urandom);
    end
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
